// File: rtl/fft_filt_pkg.sv
// Shared types and helpers for the FFT bin-masking filter.
package fft_filt_pkg;

  localparam int FFT_LGSIZE  = 9;
  localparam int FFT_LGTAPER = 5;

  typedef enum logic [1:0] {
    FILT_BYPASS = 2'd0,
    FILT_LPF    = 2'd1,
    FILT_HPF    = 2'd2,
    FILT_BPF    = 2'd3
  } filt_mode_t;

  // EDGE_LOW: passes bins at or above the cutoff (high-pass edge).
  // EDGE_HIGH: passes bins below the cutoff (low-pass edge).
  typedef enum logic {
    EDGE_LOW  = 1'b0,
    EDGE_HIGH = 1'b1
  } edge_t;

  typedef logic [FFT_LGTAPER:0] gain_t;

  // Fold an FFT bin index onto its symmetric frequency magnitude.
  function automatic int unsigned fold_bin(input int unsigned bin, input int unsigned lgsize);
    int unsigned n;
    n = 32'd1 << lgsize;
    return (bin <= (n >> 1)) ? bin : (n - bin);
  endfunction

endpackage

// File: rtl/fft_filt_edge_gain.sv
// Combinational gain for one filter edge, with optional linear taper.
module fft_filt_edge_gain
  import fft_filt_pkg::*;
#(
  parameter int LGSIZE  = FFT_LGSIZE,
  parameter int LGTAPER = FFT_LGTAPER
) (
  input  logic [LGSIZE:0]   f,
  input  logic [LGSIZE-1:0] c,
  input  logic              taper_en,
  input  edge_t             polarity,
  output logic [LGTAPER:0]  g
);

  localparam int T = 1 << LGTAPER;

  int d;

  // d counts bins into the stop side of the edge; negative means passband.
  always_comb begin
    d = 0;
    g = '0;
    if (polarity == EDGE_HIGH) d = int'(f) - int'(c);
    else                       d = int'(c) - 1 - int'(f);
    if (d < 0)                   g = (LGTAPER+1)'(T);
    else if (taper_en && d < T)  g = (LGTAPER+1)'(T - 1 - d);
    else                         g = '0;
  end

endmodule

// File: rtl/fft_bin_filter.sv
// Per-bin real gain applied to streaming FFT output, 2-clock pipeline.
module fft_bin_filter
  import fft_filt_pkg::*;
#(
  parameter int IWIDTH  = 21,
  parameter int LGSIZE  = FFT_LGSIZE,
  parameter int LGTAPER = FFT_LGTAPER
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_ce,
  input  logic [2*IWIDTH-1:0]   i_sample,
  input  logic                  i_sync,
  input  logic [1:0]            i_mode,
  input  logic [LGSIZE-1:0]     i_lo_cut,
  input  logic [LGSIZE-1:0]     i_hi_cut,
  input  logic                  i_taper_en,
  output logic                  o_ce,
  output logic [2*IWIDTH-1:0]   o_sample,
  output logic                  o_sync
);

  localparam int PW = IWIDTH + LGTAPER + 2;
  localparam logic [LGTAPER:0] GFULL = {1'b1, {LGTAPER{1'b0}}};

  logic [LGSIZE-1:0] cnt, bin;
  filt_mode_t        act_mode, use_mode;
  logic [LGSIZE-1:0] act_lo, act_hi, use_lo, use_hi;
  logic              act_tap, use_tap, latch_now;
  logic [LGSIZE:0]   f;
  logic [LGTAPER:0]  g_lpf, g_hpf, g;

  logic                s1_valid, s1_sync;
  logic [2*IWIDTH-1:0] s1_sample;
  logic [LGTAPER:0]    s1_g;

  logic signed [PW-1:0] gx, re_p, im_p, re_sh, im_sh;

  // The bin-0 sample is filtered with the config arriving alongside it.
  always_comb begin
    latch_now = i_ce && i_sync;
    use_mode  = latch_now ? filt_mode_t'(i_mode) : act_mode;
    use_lo    = latch_now ? i_lo_cut   : act_lo;
    use_hi    = latch_now ? i_hi_cut   : act_hi;
    use_tap   = latch_now ? i_taper_en : act_tap;
    bin       = i_sync ? '0 : cnt;
    f         = (LGSIZE+1)'(fold_bin(32'(bin), LGSIZE));
  end

  fft_filt_edge_gain #(.LGSIZE(LGSIZE), .LGTAPER(LGTAPER)) u_lpf_edge (
    .f(f), .c(use_hi), .taper_en(use_tap), .polarity(EDGE_HIGH), .g(g_lpf)
  );

  fft_filt_edge_gain #(.LGSIZE(LGSIZE), .LGTAPER(LGTAPER)) u_hpf_edge (
    .f(f), .c(use_lo), .taper_en(use_tap), .polarity(EDGE_LOW), .g(g_hpf)
  );

  // Select the gain for the current mode; band-pass takes the tighter edge.
  always_comb begin
    g = GFULL;
    case (use_mode)
      FILT_BYPASS: g = GFULL;
      FILT_LPF:    g = g_lpf;
      FILT_HPF:    g = g_hpf;
      FILT_BPF:    g = (g_lpf < g_hpf) ? g_lpf : g_hpf;
      default:     g = GFULL;
    endcase
  end

  // Bin counter and frame-synchronous config capture.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cnt      <= '0;
      act_mode <= FILT_BYPASS;
      act_lo   <= '0;
      act_hi   <= '0;
      act_tap  <= 1'b0;
    end else if (i_ce) begin
      cnt <= bin + 1'b1;
      if (i_sync) begin
        act_mode <= filt_mode_t'(i_mode);
        act_lo   <= i_lo_cut;
        act_hi   <= i_hi_cut;
        act_tap  <= i_taper_en;
      end
    end
  end

  // Stage 1: register sample, gain and sync with a valid bit.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      s1_valid  <= 1'b0;
      s1_sync   <= 1'b0;
      s1_sample <= '0;
      s1_g      <= '0;
    end else begin
      s1_valid  <= i_ce;
      s1_sync   <= i_ce && i_sync;
      s1_sample <= i_sample;
      s1_g      <= g;
    end
  end

  // Scale both components; the arithmetic shift floors toward minus infinity.
  always_comb begin
    gx    = PW'($signed({1'b0, s1_g}));
    re_p  = PW'($signed(s1_sample[2*IWIDTH-1:IWIDTH])) * gx;
    im_p  = PW'($signed(s1_sample[IWIDTH-1:0])) * gx;
    re_sh = re_p >>> LGTAPER;
    im_sh = im_p >>> LGTAPER;
  end

  // Stage 2: output registers; sample holds while no strobe emerges.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_ce     <= 1'b0;
      o_sync   <= 1'b0;
      o_sample <= '0;
    end else begin
      o_ce   <= s1_valid;
      o_sync <= s1_valid && s1_sync;
      if (s1_valid) o_sample <= {re_sh[IWIDTH-1:0], im_sh[IWIDTH-1:0]};
    end
  end

endmodule

// File: tb/tb_fft_bin_filter.sv
// Scoreboard bench for fft_bin_filter against a frame-level reference model.
module tb_fft_bin_filter;
  import fft_filt_pkg::*;

  localparam int IW = 21;
  localparam int N  = 512;
  localparam int T  = 32;
  localparam int G  = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          i_reset, i_ce, i_sync, i_taper_en;
  logic [2*IW-1:0] i_sample;
  logic [1:0]    i_mode;
  logic [8:0]    i_lo_cut, i_hi_cut;
  logic          o_ce, o_sync;
  logic [2*IW-1:0] o_sample;

  fft_bin_filter #(.IWIDTH(IW), .LGSIZE(9), .LGTAPER(5)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_ce(i_ce), .i_sample(i_sample),
    .i_sync(i_sync), .i_mode(i_mode), .i_lo_cut(i_lo_cut), .i_hi_cut(i_hi_cut),
    .i_taper_en(i_taper_en), .o_ce(o_ce), .o_sample(o_sample), .o_sync(o_sync)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2*IW-1:0] s;
    logic            sy;
    int              cyc;
    int              bin;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // Reference model state: latched config and running bin count.
  int m_mode = 0, m_lo = 0, m_hi = 0, m_tap = 0, m_cnt = 0;

  function automatic int ref_gain(input int mode, input int lo, input int hi,
                                  input int tap, input int f);
    int lp, hp;
    if (f < hi)                        lp = G;
    else if (tap != 0 && f < hi + T)   lp = T - 1 - (f - hi);
    else                               lp = 0;
    if (f >= lo)                       hp = G;
    else if (tap != 0 && f >= lo - T)  hp = T - 1 - (lo - 1 - f);
    else                               hp = 0;
    case (mode)
      1:       return lp;
      2:       return hp;
      3:       return (lp < hp) ? lp : hp;
      default: return G;
    endcase
  endfunction

  function automatic logic [IW-1:0] scale(input logic [IW-1:0] x, input int g);
    int v;
    v = int'($signed(x)) * g;
    v = v >>> 5;
    return IW'(v);
  endfunction

  task automatic idle();
    @(posedge clk); #1;
    i_ce     = 1'b0;
    i_sync   = 1'($urandom_range(0, 1));
    i_sample = {IW'($urandom), IW'($urandom)};
  endtask

  task automatic strobe(input logic [IW-1:0] re, input logic [IW-1:0] im, input logic sy);
    exp_t e;
    int b, f, g;
    @(posedge clk); #1;
    i_ce     = 1'b1;
    i_sync   = sy;
    i_sample = {re, im};
    if (sy) begin
      m_mode = int'(i_mode); m_lo = int'(i_lo_cut); m_hi = int'(i_hi_cut);
      m_tap = int'(i_taper_en);
      b = 0; m_cnt = 1;
    end else begin
      b = m_cnt; m_cnt = (m_cnt + 1) % N;
    end
    f = (b <= N/2) ? b : N - b;
    g = ref_gain(m_mode, m_lo, m_hi, m_tap, f);
    e.s   = {scale(re, g), scale(im, g)};
    e.sy  = sy;
    e.cyc = cyc + 2;
    e.bin = b;
    q.push_back(e);
  endtask

  task automatic set_cfg(input int mode, input int lo, input int hi, input int tap);
    i_mode = 2'(mode); i_lo_cut = 9'(lo); i_hi_cut = 9'(hi); i_taper_en = 1'(tap);
  endtask

  // kind 0: constant re=1000 im=-1000; kind 1: random data.
  task automatic frame(input int gapmax, input int kind, input int chg_bin, input int nbins);
    logic [IW-1:0] re, im;
    for (int b = 0; b < nbins; b++) begin
      repeat ($urandom_range(0, gapmax)) idle();
      if (b == chg_bin)
        set_cfg($urandom_range(0, 3), $urandom_range(0, 511), $urandom_range(0, 511),
                $urandom_range(0, 1));
      if (kind == 0) begin re = IW'(1000); im = IW'(-1000); end
      else begin re = IW'($urandom); im = IW'($urandom); end
      strobe(re, im, b == 0);
    end
  endtask

  task automatic check_zero(input string name);
    checks++;
    if (o_ce !== 1'b0 || o_sample !== '0 || o_sync !== 1'b0) begin
      errors++;
      $display("FAIL %s: got o_ce=%b o_sample=%h o_sync=%b, expected all zero",
               name, o_ce, o_sample, o_sync);
    end
  endtask

  exp_t me;

  // Monitor: every o_ce must match the oldest expected output, on its cycle.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc < cyc) begin
      me = q.pop_front();
      checks++; errors++;
      $display("FAIL missing_out: bin %0d expected at cycle %0d, no o_ce", me.bin, me.cyc);
    end
    if (o_ce) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_oce: o_ce=1 at cycle %0d, expected none", cyc);
      end else begin
        me = q.pop_front();
        if (o_sample !== me.s || o_sync !== me.sy || cyc != me.cyc) begin
          errors++;
          $display("FAIL bin%0d: got sample=%h sync=%b cycle=%0d, expected sample=%h sync=%b cycle=%0d",
                   me.bin, o_sample, o_sync, cyc, me.s, me.sy, me.cyc);
        end
      end
    end
  end

  initial begin
    i_reset = 1'b1; i_ce = 1'b0; i_sync = 1'b0; i_sample = '0;
    set_cfg(0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset_state");
    i_reset = 1'b0;

    // Single bypass sample, isolated by idle cycles.
    strobe(21'h12345, 21'h1ABCD, 1'b1);
    repeat (4) idle();

    // LPF hard and tapered edges.
    set_cfg(1, 0, 20, 0); frame(0, 0, -1, 512); idle();
    set_cfg(1, 0, 20, 1); frame(0, 0, -1, 512); idle();

    // Per-frame mode switching.
    set_cfg(2, 100, 0, 0); frame(0, 0, -1, 512);
    set_cfg(3, 50, 60, 0); frame(0, 1, -1, 512); idle();

    // Mid-frame config change with gaps; the change applies at next sync.
    set_cfg(2, 30, 0, 1); frame(3, 1, 200, 512);
    frame(3, 1, -1, 512); idle();

    // Boundary cutoffs.
    set_cfg(3, 200, 100, 0); frame(1, 1, -1, 512);
    set_cfg(3, 200, 190, 1); frame(1, 1, -1, 512);
    set_cfg(1, 256, 0, 1);   frame(0, 1, -1, 512);
    set_cfg(2, 0, 0, 1);     frame(0, 1, -1, 512);
    set_cfg(2, 256, 0, 1);   frame(1, 1, -1, 512);
    set_cfg(1, 0, 0, 0);     frame(0, 1, -1, 512); idle();

    // Reset mid-frame at bin 300 with samples still in the pipeline.
    set_cfg(1, 0, 40, 0); frame(0, 1, -1, 301);
    @(posedge clk); #1;
    i_ce = 1'b1; i_sync = 1'b0; i_reset = 1'b1;
    @(posedge clk); #1;
    q.delete();
    m_mode = 0; m_lo = 0; m_hi = 0; m_tap = 0; m_cnt = 0;
    check_zero("reset_flush");
    i_reset = 1'b0; i_ce = 1'b0;

    // Unsynced bins after reset run in bypass despite LPF on the inputs.
    set_cfg(1, 0, 5, 0);
    for (int k = 0; k < 40; k++) strobe(IW'($urandom), IW'($urandom), 1'b0);
    idle();
    frame(1, 1, -1, 512);
    idle();

    for (int k = 0; k < 10 && q.size() > 0; k++) @(posedge clk);
    @(negedge clk); #1;
    if (q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain: %0d outputs outstanding, expected 0", q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
